// File: rtl/full_subtractor.sv
// One-bit full subtractor with registered copies of its outputs and
// saturating statistics counters for sampled edges and borrow events.
module full_subtractor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             difference,
  output logic             borrow,
  output logic             difference_q,
  output logic             borrow_q,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] borrow_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             difference_s;
  logic             borrow_s;
  logic             difference_r;
  logic             borrow_r;
  logic [CNT_W-1:0] op_count_r;
  logic [CNT_W-1:0] borrow_count_r;

  function automatic logic calc_difference(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  function automatic logic calc_borrow(input logic x, input logic y, input logic z);
    return (~x & y) | (~x & z) | (y & z);
  endfunction

  // Holds at all-ones so a long run never wraps back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Subtractor core; stays live while reset is asserted.
  always_comb begin
    difference_s = calc_difference(a, b, c);
    borrow_s     = calc_borrow(a, b, c);
  end

  // Registered copies and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      difference_r   <= 1'b0;
      borrow_r       <= 1'b0;
      op_count_r     <= {CNT_W{1'b0}};
      borrow_count_r <= {CNT_W{1'b0}};
    end else begin
      difference_r <= difference_s;
      borrow_r     <= borrow_s;
      op_count_r   <= sat_inc(op_count_r);
      if (borrow_s) begin
        borrow_count_r <= sat_inc(borrow_count_r);
      end else begin
        borrow_count_r <= borrow_count_r;
      end
    end
  end

  assign difference   = difference_s;
  assign borrow       = borrow_s;
  assign difference_q = difference_r;
  assign borrow_q     = borrow_r;
  assign op_count     = op_count_r;
  assign borrow_count = borrow_count_r;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor: truth-table sweep, latency,
// counting, asynchronous reset, saturation and a random run.
module tb_full_subtractor;

  logic        clk;
  logic        rst_n;
  logic        a, b, c;
  logic        difference, borrow, difference_q, borrow_q;
  logic [15:0] op_count, borrow_count;
  logic        s_difference, s_borrow, s_difference_q, s_borrow_q;
  logic [1:0]  s_op_count, s_borrow_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [2:0] abc;
    logic       diff;
    logic       brw;
  } vec_t;

  vec_t tt [8];

  full_subtractor #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .difference(difference), .borrow(borrow),
    .difference_q(difference_q), .borrow_q(borrow_q),
    .op_count(op_count), .borrow_count(borrow_count)
  );

  full_subtractor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .difference(s_difference), .borrow(s_borrow),
    .difference_q(s_difference_q), .borrow_q(s_borrow_q),
    .op_count(s_op_count), .borrow_count(s_borrow_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int d;
    int exp_brw_cnt;
    int exp_ops;
    logic exp_d_prev, exp_b_prev;

    tt[0] = '{3'b000, 1'b0, 1'b0};
    tt[1] = '{3'b001, 1'b1, 1'b1};
    tt[2] = '{3'b010, 1'b1, 1'b1};
    tt[3] = '{3'b011, 1'b0, 1'b1};
    tt[4] = '{3'b100, 1'b1, 1'b0};
    tt[5] = '{3'b101, 1'b0, 1'b0};
    tt[6] = '{3'b110, 1'b0, 1'b0};
    tt[7] = '{3'b111, 1'b1, 1'b1};

    clk = 1'b0;
    rst_n = 1'b0;
    {a, b, c} = 3'b000;
    #1;
    check("reset_dq", 32'(difference_q), 32'd0);
    check("reset_bq", 32'(borrow_q), 32'd0);
    check("reset_op", 32'(op_count), 32'd0);
    check("reset_bc", 32'(borrow_count), 32'd0);

    // Truth table with no clock and reset held: combinational path stays live.
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = tt[i].abc;
      #5;
      check($sformatf("tt_diff_%03b", tt[i].abc), 32'(difference), 32'(tt[i].diff));
      check($sformatf("tt_brw_%03b", tt[i].abc), 32'(borrow), 32'(tt[i].brw));
      d = int'(tt[i].abc[2]) - int'(tt[i].abc[1]) - int'(tt[i].abc[0]);
      check($sformatf("identity_%03b", tt[i].abc),
            32'(int'(difference) - 2 * int'(borrow)), 32'(d));
    end

    // First edge after reset release.
    rst_n = 1'b1;
    {a, b, c} = 3'b010;
    #2;
    tick();
    check("first_dq", 32'(difference_q), 32'd1);
    check("first_bq", 32'(borrow_q), 32'd1);
    check("first_op", 32'(op_count), 32'd1);
    check("first_bc", 32'(borrow_count), 32'd1);

    // Ten edges with no borrow.
    do_reset();
    {a, b, c} = 3'b100;
    for (int i = 0; i < 10; i++) tick();
    check("ten_op", 32'(op_count), 32'd10);
    check("ten_bc", 32'(borrow_count), 32'd0);
    check("ten_bq", 32'(borrow_q), 32'd0);
    check("ten_dq", 32'(difference_q), 32'd1);

    // Asynchronous reset between edges with nonzero counts.
    #2 rst_n = 1'b0;
    #1;
    check("async_dq", 32'(difference_q), 32'd0);
    check("async_bq", 32'(borrow_q), 32'd0);
    check("async_op", 32'(op_count), 32'd0);
    check("async_bc", 32'(borrow_count), 32'd0);
    {a, b, c} = 3'b011;
    #1;
    check("async_comb_diff", 32'(difference), 32'd0);
    check("async_comb_brw", 32'(borrow), 32'd1);

    // Saturation on the narrow instance.
    #1 rst_n = 1'b1;
    {a, b, c} = 3'b111;
    #1;
    for (int i = 0; i < 6; i++) tick();
    check("sat_op", 32'(s_op_count), 32'd3);
    check("sat_bc", 32'(s_borrow_count), 32'd3);
    check("wide_op", 32'(op_count), 32'd6);
    check("wide_bc", 32'(borrow_count), 32'd6);
    #1 rst_n = 1'b0;
    #1;
    check("sat_reset_op", 32'(s_op_count), 32'd0);
    check("sat_reset_bc", 32'(s_borrow_count), 32'd0);
    #1 rst_n = 1'b1;
    #1;

    // Random run against an arithmetic reference model.
    exp_brw_cnt = 0;
    exp_ops = 0;
    for (int i = 0; i < 1000; i++) begin
      {a, b, c} = 3'($urandom_range(0, 7));
      #1;
      d = int'(a) - int'(b) - int'(c);
      exp_d_prev = d[0];
      exp_b_prev = (d < 0);
      if (exp_b_prev) exp_brw_cnt++;
      exp_ops++;
      tick();
      check($sformatf("rand_dq_%0d", i), 32'(difference_q), 32'(exp_d_prev));
      check($sformatf("rand_bq_%0d", i), 32'(borrow_q), 32'(exp_b_prev));
    end
    check("rand_bc", 32'(borrow_count), 32'(exp_brw_cnt));
    check("rand_op", 32'(op_count), 32'(exp_ops));
    check("rand_sat_op", 32'(s_op_count), 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
